pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//  Parametrised forwarding and hazard controller for the in-order miniRV pipeline; successor of the fixed 2-read-port forwarding/exception pair.
//  Owns a shadow pipeline of destination descriptors for EX..WB, resolves N read ports against FWD_STAGES producer stages, and stalls on multi-cycle loads.
//  Also handles the branch-redirect flush, the memory-wait freeze and the retire-valid tracking.
//  Sits beside the ID/EX boundary; drives the IF/ID and ID/EX register enables.
// PARAMETERS
//  XLEN          32  datapath width
//  REG_ADDR_W    5   register index width
//  NUM_RD_PORTS  2   source operands resolved per ID instruction
//  FWD_STAGES    3   producer stages tracked (1=EX, 2=MEM, ..., FWD_STAGES=WB)
//  LOAD_LAT      1   stages a load spends in the pipe before its data is forwardable (1..FWD_STAGES-1)
// PORTS
//  clk           in   1                       clock, rising edge
//  rst           in   1                       asynchronous, active-high reset
//  id_valid      in   1                       ID holds a real instruction
//  id_rs         in   NUM_RD_PORTS*REG_ADDR_W source registers, port p at [p*REG_ADDR_W +: REG_ADDR_W]
//  id_rs_used    in   NUM_RD_PORTS            port p actually reads its register
//  id_we         in   1                       ID instruction writes rd
//  id_rd         in   REG_ADDR_W              ID destination register
//  id_is_load    in   1                       ID instruction is a load
//  st_data       in   FWD_STAGES*XLEN         result value currently held by stage k (k-1 slice)
//  redirect      in   1                       EX resolved a taken branch or jump
//  mem_ready     in   1                       data memory accepts/completes the MEM-stage access this cycle
//  stall_if      out  1                       hold PC
//  stall_id      out  1                       hold IF/ID
//  flush_id      out  1                       load a bubble into IF/ID
//  bubble_ex     out  1                       load a bubble into ID/EX
//  freeze        out  1                       hold every pipeline register
//  fwd_hit       out  NUM_RD_PORTS            port p takes fwd_data instead of the RF value
//  fwd_sel       out  NUM_RD_PORTS*SEL_W      winning stage index (0 = none)
//  fwd_data      out  NUM_RD_PORTS*XLEN       forwarded operand per port
//  stage_valid   out  FWD_STAGES              shadow valid bit per stage
//  retire_valid  out  1                       WB stage commits a real instruction this cycle
// BEHAVIOUR
//  - Reset: all descriptors are invalid. All outputs are 0, except freeze, which follows ~mem_ready combinationally.
//  - Descriptor per stage k: {valid, we, rd, wait}. Stage k is "advancing" when freeze=0.
//  - On advance, stage k+1 <= stage k and wait decrements, saturating at 0.
//  - Stage 1 <= {id_valid & ~bubble_ex, id_we, id_rd, id_is_load ? LOAD_LAT : 0}.
//  - Match: port p hits stage k iff id_rs_used[p], rs != 0, and valid, we and rd==rs all hold at stage k.
//  - The lowest k wins (youngest producer). fwd_sel = k and fwd_data = st_data[k]. All of this is combinational, with 0 cycles latency.
//  - If the winning stage has wait != 0, the port raises a load-use hazard. fwd_hit stays 0 for that port.
//  - Priority: freeze > redirect > hazard.
//      freeze=~mem_ready:  stall_if=stall_id=1, flush_id=bubble_ex=0, no descriptor shifts, retire_valid=0.
//      redirect & ~freeze: flush_id=1, bubble_ex=1, stall_if=stall_id=0. Any hazard is ignored, because the ID instruction dies.
//      hazard only:        stall_if=stall_id=1, bubble_ex=1, flush_id=0.
//  - A redirect raised while frozen is not acted on. EX holds it until the freeze drops; the unit does not latch it.
//  - An x0 destination never forwards and never stalls.
//  - Several ports may hit different stages in the same cycle. They are resolved independently; any single hazard stalls.
//  - retire_valid = stage_valid[FWD_STAGES] & ~freeze.
//  - A LOAD_LAT=1 load followed by a dependent instruction gives exactly 1 bubble. LOAD_LAT=2 gives 2 bubbles.
//  - rst asserted mid-stall or mid-freeze clears every descriptor immediately. Outputs return to their reset values in the same cycle.
// STRUCTURE
//  - pipe_pkg: SEL_W=$clog2(FWD_STAGES+1), the descriptor struct/width macro, and the STAGE_EX/MEM/WB index constants.
//  - Sub-module fwd_port_mux: one instance per read port (generate loop).
//    It takes rs, used and the descriptor vector, and produces hit, sel, data and hazard.
//  - The top level holds the descriptor shift register, the priority logic and the retire tracking.
// TESTING
//  1. addi x5,... in EX, then add x6,x5,x5 in ID -> fwd_hit=2'b11, fwd_sel=1/1, fwd_data=st_data[1], no stall.
//  2. x5 written in both EX (0xAAAA) and MEM (0x5555), ID reads x5 -> youngest wins: fwd_sel=1, data=0xAAAA.
//  3. LOAD_LAT=1: lw x7 then add x8,x7,x0 -> 1 cycle of stall_if=stall_id=bubble_ex=1, then fwd_sel=2 with no stall.
//     LOAD_LAT=2 -> 2 stall cycles.
//  4. Load-use hazard and redirect in the same cycle -> flush_id=1, bubble_ex=1, stall_id=0. Next PC comes from the redirect.
//  5. mem_ready=0 for 3 cycles with a dependent lw in flight -> freeze=1 and stage_valid unchanged for 3 cycles, retire_valid=0.
//     Resumes and retires in order.
//  6. Write to x0 in EX while ID reads x0 -> fwd_hit=0, no stall.
//     Assert rst mid-stall -> all outputs 0 and stage_valid=0 within the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the miniRV hazard/forwarding unit: stage indices,
// descriptor field layout and width helpers.
package pipe_pkg;

    // Producer stage indices as seen by fwd_sel (0 means "no forward").
    localparam int unsigned STAGE_EX  = 1;
    localparam int unsigned STAGE_MEM = 2;
    localparam int unsigned STAGE_WB  = 3;

    // Descriptor bit layout, LSB first: valid, we, rd, wait counter.
    localparam int unsigned DESC_VALID = 0;
    localparam int unsigned DESC_WE    = 1;
    localparam int unsigned DESC_RD    = 2;

    // Width of a stage index including the "none" code.
    function automatic int unsigned sel_width(input int unsigned fwd_stages);
        return $clog2(fwd_stages + 1);
    endfunction

    // Wait counter must hold LOAD_LAT up to fwd_stages-1.
    function automatic int unsigned wait_width(input int unsigned fwd_stages);
        return (fwd_stages <= 2) ? 1 : $clog2(fwd_stages);
    endfunction

    // Total descriptor width for a given register index width.
    function automatic int unsigned desc_width(input int unsigned reg_addr_w,
                                               input int unsigned fwd_stages);
        return 2 + reg_addr_w + wait_width(fwd_stages);
    endfunction

    // Descriptor view for the default configuration (5-bit rd, 3 stages).
    typedef struct packed {
        logic [1:0] wait_cnt;
        logic [4:0] rd;
        logic       we;
        logic       valid;
    } desc_t;

endpackage

// File: rtl/fwd_port_mux.sv
// Per-read-port forwarding resolver: finds the youngest matching producer
// stage and reports either a forward hit or a load-use hazard.
module fwd_port_mux
    import pipe_pkg::*;
#(
    parameter  int unsigned XLEN       = 32,
    parameter  int unsigned REG_ADDR_W = 5,
    parameter  int unsigned FWD_STAGES = 3,
    localparam int unsigned SEL_W      = sel_width(FWD_STAGES),
    localparam int unsigned DESC_W     = desc_width(REG_ADDR_W, FWD_STAGES)
) (
    input  logic [REG_ADDR_W-1:0]        rs_i,
    input  logic                         used_i,
    input  logic [FWD_STAGES*DESC_W-1:0] desc_i,
    input  logic [FWD_STAGES*XLEN-1:0]   st_data_i,
    output logic                         hit_o,
    output logic [SEL_W-1:0]             sel_o,
    output logic [XLEN-1:0]              data_o,
    output logic                         hazard_o
);

    localparam int unsigned WAIT_W   = wait_width(FWD_STAGES);
    localparam int unsigned WAIT_LSB = DESC_RD + REG_ADDR_W;

    logic              found;
    logic [DESC_W-1:0] cur_desc;

    // Scan from stage 1 upward; the first match is the youngest producer.
    always_comb begin
        hit_o    = 1'b0;
        sel_o    = '0;
        data_o   = '0;
        hazard_o = 1'b0;
        found    = 1'b0;
        cur_desc = '0;
        for (int k = 0; k < FWD_STAGES; k++) begin
            cur_desc = desc_i[k*DESC_W +: DESC_W];
            if (!found && used_i && (rs_i != '0) &&
                cur_desc[DESC_VALID] && cur_desc[DESC_WE] &&
                (cur_desc[DESC_RD +: REG_ADDR_W] == rs_i)) begin
                found  = 1'b1;
                sel_o  = SEL_W'(k + 1);
                data_o = st_data_i[k*XLEN +: XLEN];
                // Load data not yet available: stall instead of forwarding.
                if (cur_desc[WAIT_LSB +: WAIT_W] != '0) begin
                    hazard_o = 1'b1;
                end else begin
                    hit_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Forwarding and hazard controller for the in-order miniRV pipeline: keeps a
// shadow pipeline of destination descriptors, resolves the read ports against
// it and arbitrates freeze, redirect flush and load-use stall.
module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter  int unsigned XLEN         = 32,
    parameter  int unsigned REG_ADDR_W   = 5,
    parameter  int unsigned NUM_RD_PORTS = 2,
    parameter  int unsigned FWD_STAGES   = 3,
    parameter  int unsigned LOAD_LAT     = 1,
    localparam int unsigned SEL_W        = sel_width(FWD_STAGES)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               id_valid,
    input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_RD_PORTS-1:0]            id_rs_used,
    input  logic                               id_we,
    input  logic [REG_ADDR_W-1:0]              id_rd,
    input  logic                               id_is_load,
    input  logic [FWD_STAGES*XLEN-1:0]         st_data,
    input  logic                               redirect,
    input  logic                               mem_ready,
    output logic                               stall_if,
    output logic                               stall_id,
    output logic                               flush_id,
    output logic                               bubble_ex,
    output logic                               freeze,
    output logic [NUM_RD_PORTS-1:0]            fwd_hit,
    output logic [NUM_RD_PORTS*SEL_W-1:0]      fwd_sel,
    output logic [NUM_RD_PORTS*XLEN-1:0]       fwd_data,
    output logic [FWD_STAGES-1:0]              stage_valid,
    output logic                               retire_valid
);

    localparam int unsigned WAIT_W   = wait_width(FWD_STAGES);
    localparam int unsigned DESC_W   = desc_width(REG_ADDR_W, FWD_STAGES);
    localparam int unsigned WAIT_LSB = DESC_RD + REG_ADDR_W;
    localparam int unsigned EX_IDX   = STAGE_EX - 1;

    logic [FWD_STAGES*DESC_W-1:0]   desc_q, desc_d;
    logic [DESC_W-1:0]              shift_desc;
    logic [WAIT_W-1:0]              id_wait;
    logic [NUM_RD_PORTS-1:0]        port_hit, port_hazard;
    logic [NUM_RD_PORTS*SEL_W-1:0]  port_sel;
    logic [NUM_RD_PORTS*XLEN-1:0]   port_data;
    logic                           frz, hazard;

    assign frz     = ~mem_ready;
    assign freeze  = frz;
    assign hazard  = |port_hazard;
    assign id_wait = id_is_load ? WAIT_W'(LOAD_LAT) : '0;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        fwd_port_mux #(
            .XLEN       (XLEN),
            .REG_ADDR_W (REG_ADDR_W),
            .FWD_STAGES (FWD_STAGES)
        ) u_fwd_port_mux (
            .rs_i      (id_rs[p*REG_ADDR_W +: REG_ADDR_W]),
            .used_i    (id_rs_used[p]),
            .desc_i    (desc_q),
            .st_data_i (st_data),
            .hit_o     (port_hit[p]),
            .sel_o     (port_sel[p*SEL_W +: SEL_W]),
            .data_o    (port_data[p*XLEN +: XLEN]),
            .hazard_o  (port_hazard[p])
        );
    end

    for (genvar k = 0; k < FWD_STAGES; k++) begin : g_valid
        assign stage_valid[k] = desc_q[k*DESC_W + DESC_VALID];
    end

    // Pipeline control: freeze beats redirect beats load-use hazard.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        if (!rst) begin
            if (frz) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (redirect) begin
                // ID instruction is on the wrong path, so its hazard is moot.
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (hazard) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    // Forwarding outputs are forced quiet while reset is asserted.
    assign fwd_hit      = rst ? '0 : port_hit;
    assign fwd_sel      = rst ? '0 : port_sel;
    assign fwd_data     = rst ? '0 : port_data;
    assign retire_valid = ~rst & stage_valid[FWD_STAGES-1] & ~frz;

    // Descriptor shift: older stages take the younger one with wait counted down.
    always_comb begin
        desc_d     = desc_q;
        shift_desc = '0;
        if (!frz) begin
            for (int k = 1; k < FWD_STAGES; k++) begin
                shift_desc = desc_q[(k-1)*DESC_W +: DESC_W];
                if (shift_desc[WAIT_LSB +: WAIT_W] != '0) begin
                    shift_desc[WAIT_LSB +: WAIT_W] =
                        shift_desc[WAIT_LSB +: WAIT_W] - WAIT_W'(1);
                end
                desc_d[k*DESC_W +: DESC_W] = shift_desc;
            end
            desc_d[EX_IDX*DESC_W +: DESC_W] = {id_wait, id_rd, id_we, id_valid & ~bubble_ex};
        end
    end

    // Descriptor register; reset clears every stage at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            desc_q <= '0;
        end else begin
            desc_q <= desc_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit: expected outputs are queued as each
// step is driven and popped/compared once the combinational outputs settle.
module tb_pipe_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic        id_we;
    logic [4:0]  id_rd;
    logic        id_is_load;
    logic [95:0] st_data;
    logic        redirect;
    logic        mem_ready;

    logic        stall_if, stall_id, flush_id, bubble_ex, freeze, retire_valid;
    logic [1:0]  fwd_hit;
    logic [3:0]  fwd_sel;
    logic [63:0] fwd_data;
    logic [2:0]  stage_valid;

    logic        stall_if2, stall_id2, flush_id2, bubble_ex2, freeze2, retire_valid2;
    logic [1:0]  fwd_hit2;
    logic [3:0]  fwd_sel2;
    logic [63:0] fwd_data2;
    logic [2:0]  stage_valid2;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic        stall;
        logic        flush;
        logic        bubble;
        logic        frz;
        logic [1:0]  hit;
        logic [3:0]  sel;
        logic [63:0] data;
        logic [2:0]  sv;
        logic        ret;
        logic        chk_fwd;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    pipe_hazard_unit #(.LOAD_LAT(1)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_we(id_we), .id_rd(id_rd), .id_is_load(id_is_load), .st_data(st_data),
        .redirect(redirect), .mem_ready(mem_ready), .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .bubble_ex(bubble_ex), .freeze(freeze), .fwd_hit(fwd_hit),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data), .stage_valid(stage_valid),
        .retire_valid(retire_valid)
    );

    pipe_hazard_unit #(.LOAD_LAT(2)) dut_ll2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_we(id_we), .id_rd(id_rd), .id_is_load(id_is_load), .st_data(st_data),
        .redirect(redirect), .mem_ready(mem_ready), .stall_if(stall_if2), .stall_id(stall_id2),
        .flush_id(flush_id2), .bubble_ex(bubble_ex2), .freeze(freeze2), .fwd_hit(fwd_hit2),
        .fwd_sel(fwd_sel2), .fwd_data(fwd_data2), .stage_valid(stage_valid2),
        .retire_valid(retire_valid2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                          input logic [1:0] used, input logic we, input logic [4:0] rd,
                          input logic load);
        id_valid   = v;
        id_rs      = {rs1, rs0};
        id_rs_used = used;
        id_we      = we;
        id_rd      = rd;
        id_is_load = load;
    endtask

    task automatic expect_out(input string step, input logic stall, input logic flush,
                              input logic bubble, input logic frz, input logic [1:0] hit,
                              input logic [3:0] sel, input logic [63:0] data,
                              input logic [2:0] sv, input logic ret, input logic chk_fwd);
        exp_t e;
        e.stall = stall; e.flush = flush; e.bubble = bubble; e.frz = frz; e.hit = hit;
        e.sel = sel; e.data = data; e.sv = sv; e.ret = ret; e.chk_fwd = chk_fwd;
        sb_q.push_back(e);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard: observed empty queue expected entry", step);
        end else begin
            e = sb_q.pop_front();
            chk({step, " stall_if"}, 64'(stall_if), 64'(e.stall));
            chk({step, " stall_id"}, 64'(stall_id), 64'(e.stall));
            chk({step, " flush_id"}, 64'(flush_id), 64'(e.flush));
            chk({step, " bubble_ex"}, 64'(bubble_ex), 64'(e.bubble));
            chk({step, " freeze"}, 64'(freeze), 64'(e.frz));
            chk({step, " fwd_hit"}, 64'(fwd_hit), 64'(e.hit));
            chk({step, " stage_valid"}, 64'(stage_valid), 64'(e.sv));
            chk({step, " retire_valid"}, 64'(retire_valid), 64'(e.ret));
            if (e.chk_fwd) begin
                chk({step, " fwd_sel"}, 64'(fwd_sel), 64'(e.sel));
                chk({step, " fwd_data"}, fwd_data, e.data);
            end
        end
    endtask

    localparam logic [63:0] D0   = 64'h0;
    localparam logic [63:0] AA_0 = 64'h0000_0000_0000_AAAA;
    localparam logic [63:0] AA_1 = 64'h0000_AAAA_0000_0000;
    localparam logic [63:0] AA_2 = 64'h0000_AAAA_0000_AAAA;
    localparam logic [63:0] MM_0 = 64'h0000_0000_0000_5555;
    localparam logic [63:0] WW_0 = 64'h0000_0000_0000_3333;
    localparam logic [63:0] MIX  = 64'h0000_5555_0000_AAAA;

    initial begin
        rst       = 1'b1;
        redirect  = 1'b0;
        mem_ready = 1'b1;
        st_data   = {32'h0000_3333, 32'h0000_5555, 32'h0000_AAAA};
        set_id(0, 0, 0, 2'b00, 0, 0, 0);

        // Reset values, and freeze tracking mem_ready even under reset.
        @(negedge clk);
        expect_out("reset", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b000, 0, 1);
        mem_ready = 1'b0;
        expect_out("reset_frz", 0, 0, 0, 1, 2'b00, 4'h0, D0, 3'b000, 0, 1);
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_out("rst_rel", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b000, 0, 1);

        // addi x5 ; add x6,x5,x5 forwards from EX on both ports.
        @(negedge clk); set_id(1, 0, 0, 2'b00, 1, 5, 0);
        expect_out("s1_addi", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b000, 0, 1);
        @(negedge clk); set_id(1, 5, 5, 2'b11, 1, 6, 0);
        expect_out("s2_ex_fwd", 0, 0, 0, 0, 2'b11, 4'b0101, AA_2, 3'b001, 0, 1);
        @(negedge clk); set_id(1, 0, 0, 2'b00, 1, 5, 0);
        expect_out("s3_addi", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b011, 0, 1);
        // Ports hit different stages; x5 also in WB but EX is younger.
        @(negedge clk); set_id(1, 5, 6, 2'b11, 1, 5, 0);
        expect_out("s4_two_stage", 0, 0, 0, 0, 2'b11, 4'b1001, MIX, 3'b111, 1, 1);
        // x5 in EX and MEM: youngest wins.
        @(negedge clk); set_id(1, 0, 5, 2'b10, 0, 0, 0);
        expect_out("s5_youngest", 0, 0, 0, 0, 2'b10, 4'b0100, AA_1, 3'b111, 1, 1);
        @(negedge clk); set_id(1, 5, 0, 2'b01, 1, 0, 0);
        expect_out("s6_mem_fwd", 0, 0, 0, 0, 2'b01, 4'b0010, MM_0, 3'b111, 1, 1);
        // x0 writer in EX, ID reads x0: nothing forwards.
        @(negedge clk); set_id(1, 0, 0, 2'b11, 1, 7, 1);
        expect_out("s7_x0", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b111, 1, 1);

        // Load-use: one bubble at LOAD_LAT=1, two at LOAD_LAT=2.
        @(negedge clk); set_id(1, 7, 0, 2'b11, 1, 8, 0);
        expect_out("s8_lu", 1, 0, 1, 0, 2'b00, 4'h0, D0, 3'b111, 1, 0);
        chk("s8_ll2_stall", 64'(stall_id2), 64'd1);
        @(negedge clk);
        expect_out("s9_lu_fwd", 0, 0, 0, 0, 2'b01, 4'b0010, MM_0, 3'b110, 1, 1);
        chk("s9_ll2_stall", 64'(stall_id2), 64'd1);
        @(negedge clk);
        expect_out("s10_wb_fwd", 0, 0, 0, 0, 2'b01, 4'b0011, WW_0, 3'b101, 1, 1);
        chk("s10_ll2_stall", 64'(stall_id2), 64'd0);

        // Load-use coinciding with redirect: flush wins.
        @(negedge clk); set_id(1, 0, 0, 2'b00, 1, 7, 1);
        expect_out("s11_lw", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b011, 0, 1);
        @(negedge clk); set_id(1, 7, 0, 2'b01, 1, 8, 0); redirect = 1'b1;
        expect_out("s12_redir", 0, 1, 1, 0, 2'b00, 4'h0, D0, 3'b111, 1, 0);

        // Three frozen cycles, one with a redirect that must be ignored.
        @(negedge clk); redirect = 1'b0; mem_ready = 1'b0;
        expect_out("s13_frz", 1, 0, 0, 1, 2'b01, 4'b0010, MM_0, 3'b110, 0, 1);
        @(negedge clk); redirect = 1'b1;
        expect_out("s14_frz_redir", 1, 0, 0, 1, 2'b01, 4'b0010, MM_0, 3'b110, 0, 1);
        @(negedge clk); redirect = 1'b0;
        expect_out("s15_frz", 1, 0, 0, 1, 2'b01, 4'b0010, MM_0, 3'b110, 0, 1);
        @(negedge clk); mem_ready = 1'b1;
        expect_out("s16_resume", 0, 0, 0, 0, 2'b01, 4'b0010, MM_0, 3'b110, 1, 1);
        @(negedge clk); set_id(0, 0, 0, 2'b00, 0, 0, 0);
        expect_out("s17_drain", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b101, 1, 1);
        @(negedge clk);
        expect_out("s18_drain", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b010, 0, 1);
        @(negedge clk);
        expect_out("s19_drain", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b100, 1, 1);

        // Reset asserted in the middle of a load-use stall.
        @(negedge clk); set_id(1, 0, 0, 2'b00, 1, 7, 1);
        expect_out("s20_lw", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b000, 0, 1);
        @(negedge clk); set_id(1, 7, 0, 2'b01, 1, 8, 0);
        expect_out("s21_lu", 1, 0, 1, 0, 2'b00, 4'h0, D0, 3'b001, 0, 0);
        rst = 1'b1;
        expect_out("s21_rst", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b000, 0, 1);
        @(negedge clk); rst = 1'b0; set_id(0, 0, 0, 2'b00, 0, 0, 0);
        expect_out("s22_idle", 0, 0, 0, 0, 2'b00, 4'h0, D0, 3'b000, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
